// File: rtl/operand_tf_pkg.sv
// Shared types and helpers for the Operand Transformer blocks.
//   scale_mode_e : overflow handling mode of the power-of-two scaler
//   lead_one_pos : index of the most significant set bit (0 for a zero input)
package operand_tf_pkg;

    typedef enum logic [1:0] {
        SCALE_NORM = 2'd0,
        SCALE_SAT  = 2'd1,
        SCALE_WRAP = 2'd2
    } scale_mode_e;

    // Functions cannot take type parameters, so the helper works on a fixed
    // wide operand; callers zero-extend their element and truncate the result
    // to the index width they need. Elements wider than LOP_MAX_W are unsupported.
    localparam int LOP_MAX_W = 64;
    localparam int LOP_IDX_W = $clog2(LOP_MAX_W);

    function automatic logic [LOP_IDX_W-1:0] lead_one_pos(input logic [LOP_MAX_W-1:0] v);
        lead_one_pos = '0;
        for (int i = 0; i < LOP_MAX_W; i++) begin
            if (v[i]) lead_one_pos = LOP_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/scaler_lane.sv
// Combinational per-lane power-of-two scaler.
//   elem   : unsigned element
//   lop    : leading-one position of elem (ignored when zero=1)
//   zero   : elem is zero
//   scale  : requested left shift
//   mode   : scale_mode_e (reserved encoding behaves as NORM)
//   result : scaled element
//   ovf    : requested shift would lose significant bits
//   shift  : shift actually applied
module scaler_lane
    import operand_tf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SCALE_W = 8,
    parameter int LOP_W   = 3
) (
    input  logic [DATA_W-1:0]  elem,
    input  logic [LOP_W-1:0]   lop,
    input  logic               zero,
    input  logic [SCALE_W-1:0] scale,
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  result,
    output logic               ovf,
    output logic [SCALE_W-1:0] shift
);

    // One bit wider than either addend so lop + scale cannot wrap.
    localparam int SUM_W = ((SCALE_W > LOP_W) ? SCALE_W : LOP_W) + 1;

    logic [SUM_W-1:0] reach;
    logic             fits;
    logic [LOP_W-1:0] norm_amt;

    assign reach    = SUM_W'(lop) + SUM_W'(scale);
    assign fits     = (reach <= SUM_W'(DATA_W - 1));
    assign norm_amt = LOP_W'(DATA_W - 1) - lop;

    // A shift count >= DATA_W yields zero, which is exactly the WRAP rule.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        shift  = '0;
        if (!zero) begin
            if (fits) begin
                result = elem << scale;
                shift  = scale;
            end else begin
                ovf = 1'b1;
                case (scale_mode_e'(mode))
                    SCALE_SAT: begin
                        result = '1;
                        shift  = scale;
                    end
                    SCALE_WRAP: begin
                        result = elem << scale;
                        shift  = scale;
                    end
                    default: begin
                        result = elem << norm_amt;
                        shift  = SCALE_W'(norm_amt);
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/operand_scaler_pipe.sv
// Two-stage multi-lane power-of-two scaler with valid/ready on both sides.
// Stage 1 captures the transaction plus per-lane leading-one position and
// zero flag; stage 2 captures the scaled results.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_elem               : LANES unsigned elements, lane i at [i*DATA_W +: DATA_W]
//   in_scale, in_mode     : shared shift amount and overflow mode
//   out_valid/out_ready   : output handshake
//   out_elem/out_ovf/out_shift : per-lane result, overflow flag, applied shift
module operand_scaler_pipe
    import operand_tf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SCALE_W = 8,
    parameter int LANES   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    in_elem,
    input  logic [SCALE_W-1:0]         in_scale,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_W-1:0]    out_elem,
    output logic [LANES-1:0]           out_ovf,
    output logic [LANES*SCALE_W-1:0]   out_shift
);

    localparam int LOP_W = $clog2(DATA_W);

    logic [LANES-1:0][DATA_W-1:0]  in_lanes;
    logic [LANES-1:0][LOP_W-1:0]   in_lop;
    logic [LANES-1:0]              in_zero;

    logic                          s1_valid;
    logic [LANES-1:0][DATA_W-1:0]  s1_elem;
    logic [LANES-1:0][LOP_W-1:0]   s1_lop;
    logic [LANES-1:0]              s1_zero;
    logic [SCALE_W-1:0]            s1_scale;
    logic [1:0]                    s1_mode;

    logic [LANES-1:0][DATA_W-1:0]  lane_res;
    logic [LANES-1:0]              lane_ovf;
    logic [LANES-1:0][SCALE_W-1:0] lane_shift;

    logic                          s2_valid;
    logic [LANES-1:0][DATA_W-1:0]  s2_elem;
    logic [LANES-1:0]              s2_ovf;
    logic [LANES-1:0][SCALE_W-1:0] s2_shift;

    logic                          s2_free;

    assign in_lanes = in_elem;

    // Stage 2 can take new data when empty or being drained this cycle;
    // stage 1 can then always move forward, so in_ready depends only on
    // pipeline state and out_ready.
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    assign out_valid = s2_valid;
    assign out_elem  = s2_elem;
    assign out_ovf   = s2_ovf;
    assign out_shift = s2_shift;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_zero[i] = (in_lanes[i] == '0);
        assign in_lop[i]  = LOP_W'(lead_one_pos(LOP_MAX_W'(in_lanes[i])));

        scaler_lane #(
            .DATA_W  (DATA_W),
            .SCALE_W (SCALE_W),
            .LOP_W   (LOP_W)
        ) u_lane (
            .elem   (s1_elem[i]),
            .lop    (s1_lop[i]),
            .zero   (s1_zero[i]),
            .scale  (s1_scale),
            .mode   (s1_mode),
            .result (lane_res[i]),
            .ovf    (lane_ovf[i]),
            .shift  (lane_shift[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_elem  <= '0;
            s1_lop   <= '0;
            s1_zero  <= '0;
            s1_scale <= '0;
            s1_mode  <= '0;
            s2_valid <= 1'b0;
            s2_elem  <= '0;
            s2_ovf   <= '0;
            s2_shift <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_elem  <= in_lanes;
                    s1_lop   <= in_lop;
                    s1_zero  <= in_zero;
                    s1_scale <= in_scale;
                    s1_mode  <= in_mode;
                end
            end
            // Result registers only load with a real transaction, so they
            // hold steady while the consumer stalls.
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_elem  <= lane_res;
                    s2_ovf   <= lane_ovf;
                    s2_shift <= lane_shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_scaler_pipe.sv
module tb_operand_scaler_pipe;

    localparam int DATA_W  = 8;
    localparam int SCALE_W = 8;
    localparam int LANES   = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [LANES*DATA_W-1:0]  in_elem = '0;
    logic [SCALE_W-1:0]       in_scale = '0;
    logic [1:0]               in_mode = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [LANES*DATA_W-1:0]  out_elem;
    logic [LANES-1:0]         out_ovf;
    logic [LANES*SCALE_W-1:0] out_shift;

    operand_scaler_pipe #(.DATA_W(DATA_W), .SCALE_W(SCALE_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_elem   (in_elem),
        .in_scale  (in_scale),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_elem  (out_elem),
        .out_ovf   (out_ovf),
        .out_shift (out_shift)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int n_out  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [LANES*DATA_W-1:0]  elem;
        logic [LANES-1:0]         ovf;
        logic [LANES*SCALE_W-1:0] shift;
    } exp_t;

    exp_t q[$];

    // Reference: treat scaling as multiplication by 2^scale and test whether
    // the product still fits in DATA_W bits.
    function automatic void ref_lane(input int e, input int s, input int m,
                                     output int r, output int o, output int sh);
        longint p;
        longint lim;
        lim = longint'(1) << DATA_W;
        r = 0; o = 0; sh = 0;
        if (e == 0) return;
        p = (s >= 40) ? lim * lim : longint'(e) * (longint'(1) << s);
        if (p < lim) begin
            r = int'(p); sh = s;
        end else begin
            o = 1;
            if (m == 1) begin
                r = int'(lim - 1); sh = s;
            end else if (m == 2) begin
                r = (s >= DATA_W) ? 0 : int'(p % lim); sh = s;
            end else begin
                r = e;
                while (r < (1 << (DATA_W - 1))) begin
                    r = r * 2;
                    sh++;
                end
            end
        end
    endfunction

    function automatic exp_t model(input logic [LANES*DATA_W-1:0] e,
                                   input logic [SCALE_W-1:0] s, input logic [1:0] m);
        exp_t x;
        int r, o, sh;
        for (int i = 0; i < LANES; i++) begin
            ref_lane(int'(e[i*DATA_W +: DATA_W]), int'(s), int'(m), r, o, sh);
            x.elem[i*DATA_W +: DATA_W]    = DATA_W'(r);
            x.ovf[i]                      = o[0];
            x.shift[i*SCALE_W +: SCALE_W] = SCALE_W'(sh);
        end
        return x;
    endfunction

    // Scoreboard: every valid output cycle (stalled or not) must show the
    // oldest outstanding model result.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid) begin
                chk("out_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("sb_elem",  64'(out_elem),  64'(q[0].elem));
                    chk("sb_ovf",   64'(out_ovf),   64'(q[0].ovf));
                    chk("sb_shift", 64'(out_shift), 64'(q[0].shift));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_elem, in_scale, in_mode));
        end
    end

    function automatic logic [LANES*DATA_W-1:0] rand_elems();
        logic [LANES*DATA_W-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*DATA_W +: DATA_W] = '0;
                1:       v[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, 15));
                default: v[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
            endcase
        end
        return v;
    endfunction

    task automatic directed(input string tag, input logic [31:0] e, input logic [7:0] s,
                            input logic [1:0] m, input logic [31:0] xe,
                            input logic [3:0] xo, input logic [31:0] xs);
        @(posedge clk); #1;
        in_valid = 1'b1; in_elem = e; in_scale = s; in_mode = m; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld"},   64'(out_valid), 64'd1);
        chk({tag, "_elem"},  64'(out_elem),  64'(xe));
        chk({tag, "_ovf"},   64'(out_ovf),   64'(xo));
        chk({tag, "_shift"}, 64'(out_shift), 64'(xs));
    endtask

    task automatic drain(input string tag);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent, n0;
        bit  saw_low, need_new, all_rdy;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_elem",  64'(out_elem),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);

        directed("norm", 32'h40001003, 8'd2, 2'd0, 32'h8000400C, 4'b1000, 32'h01000202);
        directed("sat",  32'hFF1F0121, 8'd3, 2'd1, 32'hFFF808FF, 4'b1001, 32'h03030303);
        directed("wrap", 32'h7F008001, 8'd9, 2'd2, 32'h00000000, 4'b1011, 32'h09000909);
        directed("rsv",  32'h40001003, 8'd2, 2'd3, 32'h8000400C, 4'b1000, 32'h01000202);
        directed("pass", 32'hA5015AFF, 8'd0, 2'd1, 32'hA5015AFF, 4'b0000, 32'h00000000);
        drain("directed_drained");

        // Backpressure: 5 back-to-back transactions, consumer stalls cycles 3..6.
        sent = 0; saw_low = 1'b0; need_new = 1'b1; n0 = n_out;
        for (int cyc = 0; cyc < 30 && !(sent == 5 && q.size() == 0); cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 5) begin
                if (need_new) begin
                    in_elem = rand_elems(); in_scale = SCALE_W'($urandom_range(0, 10));
                    in_mode = 2'($urandom_range(0, 3));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            need_new = in_valid && in_ready;
            if (in_valid && in_ready) sent++;
        end
        #1;
        chk("bp_sent",         64'(sent),        64'd5);
        chk("bp_inready_drop", 64'(saw_low),     64'd1);
        chk("bp_count",        64'(n_out - n0),  64'd5);
        drain("bp_drained");

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_elem = 32'h01020304; in_scale = 8'd1; in_mode = 2'd0;
        @(posedge clk); #1;
        in_elem = 32'h80402010; in_scale = 8'd4; in_mode = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_elem",  64'(out_elem),  64'd0);
        chk("mid_rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("mid_rst_out_shift", 64'(out_shift), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        n0 = n_out;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_rst_no_stale", 64'(n_out - n0), 64'd0);

        // Random sweep with random valid/ready.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            in_elem   = rand_elems();
            in_scale  = SCALE_W'($urandom_range(0, 20));
            in_mode   = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain("sweep_drained");

        // Full throughput: continuous valid/ready yields one result per cycle.
        n0 = n_out; all_rdy = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            in_elem = rand_elems(); in_scale = SCALE_W'($urandom_range(0, 20));
            in_mode = 2'($urandom_range(0, 3)); in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            if (!in_ready) all_rdy = 1'b0;
        end
        #1;
        chk("tp_in_ready", 64'(all_rdy),     64'd1);
        chk("tp_count",    64'(n_out - n0),  64'd22);
        drain("tp_drained");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
